// File: rtl/sync_transfer_arbiter_pkg.sv
// Shared definitions for the clk_in-side transfer arbiter: FSM encodings
// and the counter sizing helper also used by the clk_out-side receiver.
package sync_transfer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Bits needed to hold 0..max_val; never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, otherwise wrapping from index 0.
module sync_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sync_transfer_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack synchronizer path
// between NUM_REQ clk_in-domain requesters, with setup delay and ack timeout.
module sync_transfer_arbiter
  import sync_transfer_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 10,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk_in,
  input  logic                          n_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          req_err,
  output logic [DATA_WIDTH-1:0]         to_sync_data,
  output logic                          to_sync_req,
  input  logic                          ack_sync,
  input  logic                          clr_err,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IDX_W = cnt_width(NUM_REQ - 1);
  localparam int SCW   = cnt_width(SETUP_CYCLES);
  localparam int TCW   = cnt_width(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  logic [SCW-1:0]          setup_cnt_q, setup_cnt_d;
  logic [TCW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic                    req_q, req_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    rerr_q, rerr_d;
  logic                    err_q, err_d;

  logic [NUM_REQ-1:0]      pick_grant;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic [DATA_WIDTH-1:0]   pick_data;
  logic [NUM_REQ-1:0]      win_onehot;
  logic [IDX_W-1:0]        ptr_next;
  logic                    tmo_hit;
  logic                    tmo_fire;

  sync_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign win_onehot = NUM_REQ'(1) << win_q;
  assign ptr_next   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    data_d      = data_q;
    win_d       = win_q;
    ptr_d       = ptr_q;
    req_d       = req_q;
    done_d      = '0;
    rerr_d      = 1'b0;
    tmo_fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Hold off while done is still pulsing so a requester that has not yet
        // dropped req_valid is not granted again.
        if (pick_any && !ack_sync && (done_q == '0)) begin
          data_d      = pick_data;
          win_d       = pick_idx;
          setup_cnt_d = '0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (setup_cnt_q == SCW'(SETUP_CYCLES - 1)) begin
          req_d     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = ST_REQ;
        end else begin
          setup_cnt_d = setup_cnt_q + SCW'(1);
        end
      end
      ST_REQ: begin
        if (ack_sync) begin
          req_d     = 1'b0;
          tmo_cnt_d = '0;
          state_d   = ST_RELEASE;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
      end
      ST_RELEASE: begin
        if (!ack_sync) begin
          done_d  = win_onehot;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_fire) begin
      req_d   = 1'b0;
      done_d  = win_onehot;
      rerr_d  = 1'b1;
      ptr_d   = ptr_next;
      state_d = ST_IDLE;
    end
    err_d = tmo_fire ? 1'b1 : (clr_err ? 1'b0 : err_q);
  end

  always_ff @(posedge clk_in or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      data_q      <= '0;
      win_q       <= '0;
      ptr_q       <= '0;
      req_q       <= 1'b0;
      done_q      <= '0;
      rerr_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      data_q      <= data_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      req_q       <= req_d;
      done_q      <= done_d;
      rerr_q      <= rerr_d;
      err_q       <= err_d;
    end
  end

  assign to_sync_data = data_q;
  assign to_sync_req  = req_q;
  assign req_done     = done_q;
  assign req_err      = rerr_q;
  assign timeout_err  = err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sync_transfer_arbiter.sv
// Directed bench for sync_transfer_arbiter; the ack model echoes
// to_sync_req three clk_in cycles later.
module tb_sync_transfer_arbiter;

  logic        clk_in = 1'b0;
  logic        n_reset;
  logic [1:0]  req_valid;
  logic [19:0] req_data;
  logic [1:0]  req_done;
  logic        req_err;
  logic [9:0]  to_sync_data;
  logic        to_sync_req;
  logic        ack_sync;
  logic        clr_err;
  logic        busy;
  logic        timeout_err;

  logic [9:0]  d0, d1;
  logic        ack_en, ack_force;
  logic [2:0]  ack_sh;

  int vectors    = 0;
  int miscompares = 0;

  assign req_data = {d1, d0};
  assign ack_sync = ack_force | (ack_en & ack_sh[2]);

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or negedge n_reset) begin
    if (!n_reset) ack_sh <= 3'b000;
    else          ack_sh <= {ack_sh[1:0], to_sync_req};
  end

  sync_transfer_arbiter #(
    .NUM_REQ        (2),
    .DATA_WIDTH     (10),
    .SETUP_CYCLES   (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_in       (clk_in),
    .n_reset      (n_reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_done     (req_done),
    .req_err      (req_err),
    .to_sync_data (to_sync_data),
    .to_sync_req  (to_sync_req),
    .ack_sync     (ack_sync),
    .clr_err      (clr_err),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    vectors++;
    if (to_sync_req !== 1'b0 || busy !== 1'b0 || to_sync_data !== 10'h000 ||
        req_done !== 2'b00 || req_err !== 1'b0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got req=%b busy=%b data=%h done=%b err=%b terr=%b want all 0",
               to_sync_req, busy, to_sync_data, req_done, req_err, timeout_err);
    end
    n_reset = 1'b1;
    @(posedge clk_in); #1;
  endtask

  task automatic test_contention();
    int n;
    logic [9:0] exp_w;
    logic [1:0] exp_d;
    d0 = 10'h155; d1 = 10'h2AA; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_w = (k % 2 == 0) ? 10'h155 : 10'h2AA;
      exp_d = (k % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (req_done === 2'b00 && n < 40) begin
        @(posedge clk_in); #1; n++;
      end
      vectors++;
      if (to_sync_data !== exp_w || req_done !== exp_d || req_err !== 1'b0) begin
        miscompares++;
        $display("FAIL contention_%0d got data=%h done=%b err=%b want data=%h done=%b err=0",
                 k, to_sync_data, req_done, req_err, exp_w, exp_d);
      end
      if (k == 3) req_valid = 2'b00;
      @(posedge clk_in); #1;
    end
  endtask

  task automatic test_single();
    int n;
    d0 = 10'h3FF; req_valid = 2'b01;
    @(posedge clk_in); #1;
    vectors++;
    if (to_sync_data !== 10'h3FF || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant got data=%h busy=%b want 3ff/1", to_sync_data, busy);
    end
    @(posedge clk_in); #1;
    vectors++;
    if (to_sync_req !== 1'b0) begin
      miscompares++;
      $display("FAIL single_setup got req=%b want 0", to_sync_req);
    end
    @(posedge clk_in); #1;
    vectors++;
    if (to_sync_req !== 1'b1) begin
      miscompares++;
      $display("FAIL single_req_rise got req=%b want 1", to_sync_req);
    end
    n = 0;
    while (req_done === 2'b00 && n < 40) begin
      @(posedge clk_in); #1; n++;
    end
    vectors++;
    if (req_done !== 2'b01 || req_err !== 1'b0 || n != 8 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done got done=%b err=%b cycles=%0d busy=%b want 01/0/8/0",
               req_done, req_err, n, busy);
    end
    req_valid = 2'b00;
    @(posedge clk_in); #1;
    vectors++;
    if (busy !== 1'b0 || req_done !== 2'b00) begin
      miscompares++;
      $display("FAIL single_idle got busy=%b done=%b want 0/00", busy, req_done);
    end
  endtask

  task automatic test_data_hold();
    int n;
    d0 = 10'h3FF; req_valid = 2'b01;
    n = 0;
    while (to_sync_req !== 1'b1 && n < 10) begin
      @(posedge clk_in); #1; n++;
    end
    d0 = 10'h000;
    @(posedge clk_in); #1;
    vectors++;
    if (to_sync_data !== 10'h3FF) begin
      miscompares++;
      $display("FAIL hold_req got data=%h want 3ff", to_sync_data);
    end
    n = 0;
    while (req_done === 2'b00 && n < 40) begin
      @(posedge clk_in); #1; n++;
    end
    vectors++;
    if (to_sync_data !== 10'h3FF || req_done !== 2'b01) begin
      miscompares++;
      $display("FAIL hold_done got data=%h done=%b want 3ff/01", to_sync_data, req_done);
    end
    @(posedge clk_in); #1;
    vectors++;
    if (busy !== 1'b0 || to_sync_data !== 10'h3FF) begin
      miscompares++;
      $display("FAIL hold_gap got busy=%b data=%h want 0/3ff", busy, to_sync_data);
    end
    @(posedge clk_in); #1;
    vectors++;
    if (busy !== 1'b1 || to_sync_data !== 10'h000) begin
      miscompares++;
      $display("FAIL hold_regrant got busy=%b data=%h want 1/000", busy, to_sync_data);
    end
    n = 0;
    while (req_done === 2'b00 && n < 40) begin
      @(posedge clk_in); #1; n++;
    end
    req_valid = 2'b00;
    @(posedge clk_in); #1;
  endtask

  task automatic test_timeout();
    int n;
    ack_en = 1'b0;
    d0 = 10'h0AB; req_valid = 2'b01;
    n = 0;
    while (to_sync_req !== 1'b1 && n < 10) begin
      @(posedge clk_in); #1; n++;
    end
    vectors++;
    if (to_sync_req !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_req_rise got req=%b want 1", to_sync_req);
    end
    n = 0;
    while (to_sync_req === 1'b1 && n < 40) begin
      @(posedge clk_in); #1; n++;
    end
    vectors++;
    if (n != 16 || req_done !== 2'b01 || req_err !== 1'b1 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_fire got cycles=%0d done=%b err=%b terr=%b want 16/01/1/1",
               n, req_done, req_err, timeout_err);
    end
    req_valid = 2'b00;
    @(posedge clk_in); #1;
    vectors++;
    if (timeout_err !== 1'b1 || req_err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_sticky got terr=%b err=%b busy=%b want 1/0/0",
               timeout_err, req_err, busy);
    end
    clr_err = 1'b1;
    @(posedge clk_in); #1;
    clr_err = 1'b0;
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear got terr=%b want 0", timeout_err);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_stuck_ack();
    int n;
    ack_force = 1'b1;
    d0 = 10'h123; req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_in); #1;
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL stuck_nogrant_%0d got busy=%b want 0", k, busy);
      end
    end
    ack_force = 1'b0;
    @(posedge clk_in); #1;
    vectors++;
    if (busy !== 1'b1 || to_sync_data !== 10'h123) begin
      miscompares++;
      $display("FAIL stuck_release got busy=%b data=%h want 1/123", busy, to_sync_data);
    end
    n = 0;
    while (req_done === 2'b00 && n < 40) begin
      @(posedge clk_in); #1; n++;
    end
    vectors++;
    if (req_done !== 2'b01) begin
      miscompares++;
      $display("FAIL stuck_done got done=%b want 01", req_done);
    end
    req_valid = 2'b00;
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset_mid_req();
    int n;
    d0 = 10'h155; d1 = 10'h2AA; req_valid = 2'b11;
    n = 0;
    while (to_sync_req !== 1'b1 && n < 10) begin
      @(posedge clk_in); #1; n++;
    end
    vectors++;
    if (to_sync_req !== 1'b1 || to_sync_data !== 10'h2AA) begin
      miscompares++;
      $display("FAIL midreset_pre got req=%b data=%h want 1/2aa", to_sync_req, to_sync_data);
    end
    #2 n_reset = 1'b0;
    #1;
    vectors++;
    if (to_sync_req !== 1'b0 || busy !== 1'b0 || to_sync_data !== 10'h000) begin
      miscompares++;
      $display("FAIL midreset_async got req=%b busy=%b data=%h want 0/0/000",
               to_sync_req, busy, to_sync_data);
    end
    #2 n_reset = 1'b1;
    @(posedge clk_in); #1;
    vectors++;
    if (busy !== 1'b1 || to_sync_data !== 10'h155) begin
      miscompares++;
      $display("FAIL midreset_first_grant got busy=%b data=%h want 1/155", busy, to_sync_data);
    end
    n = 0;
    while (req_done === 2'b00 && n < 40) begin
      @(posedge clk_in); #1; n++;
    end
    vectors++;
    if (req_done !== 2'b01) begin
      miscompares++;
      $display("FAIL midreset_done got done=%b want 01", req_done);
    end
    req_valid = 2'b00;
    @(posedge clk_in); #1;
  endtask

  initial begin
    n_reset   = 1'b0;
    req_valid = 2'b00;
    d0        = 10'h000;
    d1        = 10'h000;
    clr_err   = 1'b0;
    ack_en    = 1'b1;
    ack_force = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_data_hold();
    test_timeout();
    test_stuck_ack();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
